// File: rtl/pong_game_ctrl_pkg.sv
// Shared Pong encodings: game state codes used by the sequencer, paddle and ball blocks,
// plus player indices.
package pong_game_ctrl_pkg;

  typedef enum logic [1:0] {
    StStart = 2'b00,
    StServe = 2'b01,
    StPlay  = 2'b10,
    StDone  = 2'b11
  } game_state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int unsigned ScoreW = 4;

endpackage

// File: rtl/pong_edge_det.sv
// Single-bit rising-edge detector; the output is combinational against a one-cycle-old copy
// of the input, so a held level yields exactly one event.
module pong_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: owns START/SERVE/PLAY/DONE, per-player scores, server selection,
// the serve pause timer and the winner flag.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter logic [3:0]       WIN_SCORE    = 4'd7,
  parameter int unsigned      CNT_W        = 27,
  parameter logic [CNT_W-1:0] SERVE_CYCLES = CNT_W'(100_000_000)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_btn,
  input  logic                miss_left,
  input  logic                miss_right,
  output logic [1:0]          state,
  output logic [ScoreW-1:0]   score0,
  output logic [ScoreW-1:0]   score1,
  output logic                server,
  output logic                launch,
  output logic                ball_hold,
  output logic                winner
);

  localparam logic [CNT_W-1:0] ServeLast = SERVE_CYCLES - CNT_W'(1);

  game_state_e       state_q, state_d;
  logic [ScoreW-1:0] score0_q, score0_d;
  logic [ScoreW-1:0] score1_q, score1_d;
  logic              server_q, server_d;
  logic              winner_q, winner_d;
  logic              launch_q, launch_d;
  logic [CNT_W-1:0]  timer_q, timer_d;

  logic              start_rise;
  logic [ScoreW-1:0] score0_inc;
  logic [ScoreW-1:0] score1_inc;

  pong_edge_det u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (start_btn),
    .rise (start_rise)
  );

  // Scores stay below WIN_SCORE while in PLAY, so the increment cannot wrap.
  assign score0_inc = score0_q + 4'd1;
  assign score1_inc = score1_q + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StStart;
      score0_q <= '0;
      score1_q <= '0;
      server_q <= P0;
      winner_q <= P0;
      launch_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      score0_q <= score0_d;
      score1_q <= score1_d;
      server_q <= server_d;
      winner_q <= winner_d;
      launch_q <= launch_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    score0_d = score0_q;
    score1_d = score1_q;
    server_d = server_q;
    winner_d = winner_q;
    launch_d = 1'b0;
    timer_d  = timer_q;

    unique case (state_q)
      StStart: begin
        score0_d = '0;
        score1_d = '0;
        timer_d  = '0;
        if (start_rise) begin
          state_d  = StServe;
          server_d = P0;
        end
      end

      StServe: begin
        if (timer_q == ServeLast) begin
          state_d  = StPlay;
          timer_d  = '0;
          launch_d = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      StPlay: begin
        if (miss_left && !miss_right) begin
          score1_d = score1_inc;
          if (score1_inc == WIN_SCORE) begin
            state_d  = StDone;
            winner_d = P1;
          end else begin
            state_d  = StServe;
            server_d = P0;
          end
        end else if (miss_right && !miss_left) begin
          score0_d = score0_inc;
          if (score0_inc == WIN_SCORE) begin
            state_d  = StDone;
            winner_d = P0;
          end else begin
            state_d  = StServe;
            server_d = P1;
          end
        end else if (miss_left && miss_right) begin
          // Double miss is a let: replay the serve with no score change.
          state_d = StServe;
        end
      end

      StDone: begin
        if (start_rise) begin
          state_d  = StStart;
          score0_d = '0;
          score1_d = '0;
          server_d = P0;
        end
      end

      default: state_d = StStart;
    endcase
  end

  assign state     = state_q;
  assign score0    = score0_q;
  assign score1    = score1_q;
  assign server    = server_q;
  assign winner    = winner_q;
  assign launch    = launch_q;
  assign ball_hold = (state_q != StPlay);

endmodule
